inst_fetch_queue: RTL and testbench

Parametrised instruction buffer between the I-cache fetch port and the N-wide decode stage. Accepts fetch packets of up to FETCH_W instructions, stores them in a circular queue, and presents the oldest ISSUE_W entries to the decoders. Decoders consume entries strictly in order. A redirect flush from branch resolution or interrupt entry empties the queue in one cycle.

---
 rtl/inst_fetch_queue_pkg.sv | 25 ++
 rtl/fq_ram.sv | 47 ++++
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 tb/tb_inst_fetch_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths, zero
// constants and the in-order leading-ones counter used by both handshakes.
package inst_fetch_queue_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int LO_MAX_W   = 32;

    localparam logic [PC_W_DEF-1:0]   ZERO_PC   = '0;
    localparam logic [INST_W_DEF-1:0] ZERO_INST = '0;

    // Counts consecutive ones from bit 0; everything above the first zero is ignored.
    function automatic int unsigned leading_ones(input logic [LO_MAX_W-1:0] vec);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < LO_MAX_W; i++) begin
            run = run & vec[i];
            if (run) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/fq_ram.sv
// Entry storage for the fetch queue: FETCH_W write lanes and ISSUE_W read lanes,
// each group at consecutive addresses that wrap modulo DEPTH.
module fq_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 4,
    parameter int ISSUE_W = 2,
    parameter int PC_W    = PC_W_DEF,
    parameter int INST_W  = INST_W_DEF,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic [FETCH_W-1:0]        wr_en,
    input  logic [AW-1:0]             wr_base,
    input  logic [FETCH_W*PC_W-1:0]   wr_pc,
    input  logic [FETCH_W*INST_W-1:0] wr_inst,
    input  logic [AW-1:0]             rd_base,
    output logic [ISSUE_W*PC_W-1:0]   rd_pc,
    output logic [ISSUE_W*INST_W-1:0] rd_inst
);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the head/count
    // registers, so stale contents are never presented.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                pc_mem[wr_base + AW'(k)]   <= wr_pc[k*PC_W +: PC_W];
                inst_mem[wr_base + AW'(k)] <= wr_inst[k*INST_W +: INST_W];
            end
        end
    end

    // NOTE: outputs get a default before the loop so no latch can be inferred.
    always_comb begin
        rd_pc   = '0;
        rd_inst = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_pc[i*PC_W +: PC_W]       = pc_mem[rd_base + AW'(i)];
            rd_inst[i*INST_W +: INST_W] = inst_mem[rd_base + AW'(i)];
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between I-cache fetch and an ISSUE_W-wide decoder;
// holds pointers, occupancy and both handshakes, with flush emptying it in one cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int FETCH_W = 4,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 16,
    parameter int PC_W    = PC_W_DEF,
    parameter int INST_W  = INST_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FETCH_W-1:0]          in_mask,
    input  logic [FETCH_W*PC_W-1:0]     in_pc,
    input  logic [FETCH_W*INST_W-1:0]   in_inst,
    input  logic                        flush,
    output logic [ISSUE_W-1:0]          out_valid,
    input  logic [ISSUE_W-1:0]          out_ready,
    output logic [ISSUE_W*PC_W-1:0]     out_pc,
    output logic [ISSUE_W*INST_W-1:0]   out_inst,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]             head;
    logic [AW-1:0]             tail;
    logic                      enq_fire;
    logic [CW-1:0]             n_in;
    logic [CW-1:0]             n_out;
    logic [FETCH_W-1:0]        wr_en;
    logic [ISSUE_W*PC_W-1:0]   rd_pc;
    logic [ISSUE_W*INST_W-1:0] rd_inst;

    // Registered occupancy only: a same-cycle dequeue never opens the input.
    assign in_ready = (count <= CW'(DEPTH - FETCH_W));
    assign enq_fire = in_valid & in_ready & ~flush;

    always_comb begin
        n_in  = enq_fire ? CW'(leading_ones(LO_MAX_W'(in_mask))) : '0;
        wr_en = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            wr_en[k] = (CW'(k) < n_in);
        end
    end

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = (count > CW'(i));
        end
    end

    assign n_out = CW'(leading_ones(LO_MAX_W'(out_valid & out_ready)));

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_pc[i*PC_W +: PC_W]       = out_valid[i] ? rd_pc[i*PC_W +: PC_W]
                                                        : PC_W'(ZERO_PC);
            out_inst[i*INST_W +: INST_W] = out_valid[i] ? rd_inst[i*INST_W +: INST_W]
                                                        : INST_W'(ZERO_INST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_out);
            tail  <= tail + AW'(n_in);
            count <= count + n_in - n_out;
        end
    end

    fq_ram #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (tail),
        .wr_pc   (in_pc),
        .wr_inst (in_inst),
        .rd_base (head),
        .rd_pc   (rd_pc),
        .rd_inst (rd_inst)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: a queue-based model of the buffer is
// compared against the DUT every cycle, with literal checks on the directed steps.
module tb_inst_fetch_queue;

    localparam int FETCH_W = 4;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 16;
    localparam int PC_W    = 64;
    localparam int INST_W  = 32;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [FETCH_W-1:0]         in_mask;
    logic [FETCH_W*PC_W-1:0]    in_pc;
    logic [FETCH_W*INST_W-1:0]  in_inst;
    logic                       flush;
    logic [ISSUE_W-1:0]         out_valid;
    logic [ISSUE_W-1:0]         out_ready;
    logic [ISSUE_W*PC_W-1:0]    out_pc;
    logic [ISSUE_W*INST_W-1:0]  out_inst;
    logic [$clog2(DEPTH):0]     count;

    ent_t model_q[$];
    int   n_checks;
    int   n_fail;

    inst_fetch_queue #(
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INST_W  (INST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected outputs derived from the model queue contents alone.
    task automatic compare_all();
        logic [ISSUE_W-1:0]        e_valid;
        logic [ISSUE_W*PC_W-1:0]   e_pc;
        logic [ISSUE_W*INST_W-1:0] e_inst;
        e_valid = '0;
        e_pc    = '0;
        e_inst  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (model_q.size() > i) begin
                e_valid[i]                  = 1'b1;
                e_pc[i*PC_W +: PC_W]        = model_q[i].pc;
                e_inst[i*INST_W +: INST_W]  = model_q[i].inst;
            end
        end
        check("count",     128'(count),     128'(model_q.size()));
        check("in_ready",  128'(in_ready),  128'((DEPTH - model_q.size()) >= FETCH_W));
        check("out_valid", 128'(out_valid), 128'(e_valid));
        check("out_pc",    128'(out_pc),    128'(e_pc));
        check("out_inst",  128'(out_inst),  128'(e_inst));
    endtask

    task automatic model_step();
        int  nin;
        int  nout;
        bit  fire;
        nin = 0;
        while (nin < FETCH_W && in_mask[nin]) nin++;
        nout = 0;
        while (nout < ISSUE_W && model_q.size() > nout && out_ready[nout]) nout++;
        if (flush) begin
            model_q.delete();
        end else begin
            fire = in_valid && ((DEPTH - model_q.size()) >= FETCH_W);
            repeat (nout) void'(model_q.pop_front());
            if (fire) begin
                for (int k = 0; k < nin; k++) begin
                    ent_t e;
                    e.pc   = in_pc[k*PC_W +: PC_W];
                    e.inst = in_inst[k*INST_W +: INST_W];
                    model_q.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic [FETCH_W-1:0] m, input logic [PC_W-1:0] base,
                          input logic f, input logic [ISSUE_W-1:0] r);
        in_valid  = v;
        in_mask   = m;
        flush     = f;
        out_ready = r;
        for (int k = 0; k < FETCH_W; k++) begin
            in_pc[k*PC_W +: PC_W]       = base + PC_W'(4 * k);
            in_inst[k*INST_W +: INST_W] = $urandom();
        end
    endtask

    initial begin
        logic [ISSUE_W-1:0] rdy;
        logic [FETCH_W-1:0] msk;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
        check("reset_count", 128'(count), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_pc", 128'(out_pc), 128'(0));

        set_in(1'b1, 4'b1111, 64'h8000_0000, 1'b0, 2'b00);
        tick();
        check("first_count", 128'(count), 128'(4));
        check("first_out_valid", 128'(out_valid), 128'(2'b11));
        check("first_out_pc", 128'(out_pc), {64'h8000_0004, 64'h8000_0000});

        set_in(1'b0, '0, '0, 1'b0, 2'b10);
        tick();
        check("skip_count", 128'(count), 128'(4));
        set_in(1'b0, '0, '0, 1'b0, 2'b01);
        tick();
        check("one_count", 128'(count), 128'(3));
        check("one_slot0_pc", 128'(out_pc[PC_W-1:0]), 128'(64'h8000_0004));

        set_in(1'b1, 4'b1011, 64'h9000_0000, 1'b0, 2'b00);
        tick();
        check("mask1011_count", 128'(count), 128'(5));
        set_in(1'b1, 4'b0000, 64'h9100_0000, 1'b0, 2'b00);
        tick();
        check("mask0000_count", 128'(count), 128'(5));

        set_in(1'b1, 4'b1111, 64'hA000_0000, 1'b0, 2'b00);
        tick();
        set_in(1'b1, 4'b1111, 64'hA000_0010, 1'b0, 2'b00);
        tick();
        check("full_count", 128'(count), 128'(13));
        check("full_in_ready", 128'(in_ready), 128'(0));

        set_in(1'b1, 4'b1111, 64'hB000_0000, 1'b0, 2'b11);
        tick();
        check("drain_count", 128'(count), 128'(11));
        check("drain_in_ready", 128'(in_ready), 128'(1));

        for (int j = 0; j < 8; j++) begin
            set_in(1'b1, 4'b1111, 64'hC000_0000 + 64'(16 * j), 1'b0, 2'b11);
            tick();
        end

        while (model_q.size() > 6) begin
            set_in(1'b0, '0, '0, 1'b0, (model_q.size() - 6 >= 2) ? 2'b11 : 2'b01);
            tick();
        end
        check("preflush_count", 128'(count), 128'(6));
        set_in(1'b1, 4'b1111, 64'hDEAD_0000, 1'b1, 2'b11);
        tick();
        check("flush_count", 128'(count), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_pc", 128'(out_pc), 128'(0));
        set_in(1'b1, 4'b1111, 64'hE000_0000, 1'b0, 2'b00);
        tick();
        check("postflush_pc", 128'(out_pc[PC_W-1:0]), 128'(64'hE000_0000));

        set_in(1'b1, 4'b1111, 64'hE100_0000, 1'b0, 2'b00);
        tick();
        set_in(1'b1, 4'b0001, 64'hE200_0000, 1'b0, 2'b00);
        tick();
        check("prereset_count", 128'(count), 128'(9));

        set_in(1'b0, '0, '0, 1'b0, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        check("async_count", 128'(count), 128'(0));
        check("async_out_valid", 128'(out_valid), 128'(0));
        check("async_out_pc", 128'(out_pc), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
        check("release_in_ready", 128'(in_ready), 128'(1));

        for (int c = 0; c < 3000; c++) begin
            int drain_pct;
            drain_pct = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 60 : 95);
            msk = ($urandom_range(99) < 65) ? 4'b1111 : 4'($urandom());
            rdy = '0;
            for (int i = 0; i < ISSUE_W; i++) begin
                rdy[i] = ($urandom_range(99) < drain_pct);
            end
            set_in($urandom_range(99) < 75, msk, {32'h4000_0000, 32'($urandom()) & 32'hFFFF_FFF0},
                   $urandom_range(99) < 2, rdy);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
